// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encodings, opcode map and class flags.
// Imported by the main control FSM, its opcode decoder and pc_control.
package cpu_pkg;

   localparam int OP_W = 6;
   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IF  = 3'b000,
      ST_ID  = 3'b001,
      ST_EX  = 3'b010,
      ST_MEM = 3'b011,
      ST_WB  = 3'b100
   } state_t;

   localparam logic [OP_W-1:0] OP_AND     = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADD     = 6'b000001;
   localparam logic [OP_W-1:0] OP_SUB     = 6'b000010;
   localparam logic [OP_W-1:0] OP_IALU_LO = 6'b000011;
   localparam logic [OP_W-1:0] OP_IALU_HI = 6'b000100;
   localparam logic [OP_W-1:0] OP_LW      = 6'b000101;
   localparam logic [OP_W-1:0] OP_SW      = 6'b000110;
   localparam logic [OP_W-1:0] OP_BR_LO   = 6'b001000;
   localparam logic [OP_W-1:0] OP_BR_HI   = 6'b001011;
   localparam logic [OP_W-1:0] OP_JMP     = 6'b001100;
   localparam logic [OP_W-1:0] OP_CALL    = 6'b001101;
   localparam logic [OP_W-1:0] OP_RET     = 6'b001110;

   // One-hot instruction class; all-zero means the opcode is treated as a NOP.
   typedef struct packed {
      logic is_r;
      logic is_ialu;
      logic is_lw;
      logic is_sw;
      logic is_br;
      logic is_jmp;
      logic is_call;
      logic is_ret;
   } op_class_t;

   function automatic logic op_in_range(input logic [OP_W-1:0] op,
                                        input logic [OP_W-1:0] lo,
                                        input logic [OP_W-1:0] hi);
      return (op >= lo) && (op <= hi);
   endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: maps the IR opcode field to one-hot class flags.
module op_class_decode
   import cpu_pkg::*;
#(
   parameter int OP_W = cpu_pkg::OP_W
) (
   input  logic [OP_W-1:0] op,
   output op_class_t       cls
);

   always_comb begin
      cls         = '0;
      cls.is_r    = op_in_range(op, OP_AND, OP_SUB);
      cls.is_ialu = op_in_range(op, OP_IALU_LO, OP_IALU_HI);
      cls.is_lw   = (op == OP_LW);
      cls.is_sw   = (op == OP_SW);
      cls.is_br   = op_in_range(op, OP_BR_LO, OP_BR_HI);
      cls.is_jmp  = (op == OP_JMP);
      cls.is_call = (op == OP_CALL);
      cls.is_ret  = (op == OP_RET);
   end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control: sequences IF/ID/EX/MEM/WB and drives the datapath
// enables; the registered state bus is consumed by pc_control.
module main_control_fsm
   import cpu_pkg::*;
#(
   parameter int OP_W = cpu_pkg::OP_W,
   parameter int ST_W = cpu_pkg::ST_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic [ST_W-1:0] state,
   output logic            pc_write,
   output logic            ir_write,
   output logic            imem_read,
   output logic            dmem_read,
   output logic            dmem_write,
   output logic            reg_write,
   output logic            alu_src_imm,
   output logic            wb_sel_mem,
   output logic            ret_push
);

   logic [ST_W-1:0] state_q;
   logic [ST_W-1:0] state_d;
   op_class_t       cls;
   logic            is_nop;
   logic            is_seq;

   op_class_decode #(
      .OP_W (OP_W)
   ) u_op_class_decode (
      .op  (op),
      .cls (cls)
   );

   assign is_nop = ~|cls;
   assign is_seq = cls.is_r | cls.is_ialu | cls.is_lw | cls.is_sw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = ST_IF;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      imem_read   = 1'b0;
      dmem_read   = 1'b0;
      dmem_write  = 1'b0;
      reg_write   = 1'b0;
      alu_src_imm = 1'b0;
      wb_sel_mem  = 1'b0;
      ret_push    = 1'b0;

      case (state_q)
         ST_IF: begin
            imem_read = 1'b1;
            ir_write  = 1'b1;
            state_d   = ST_ID;
         end
         ST_ID: begin
            if (cls.is_br) begin
               state_d = ST_EX;
            end else if (cls.is_jmp || cls.is_ret || cls.is_call || is_nop) begin
               pc_write = 1'b1;
               ret_push = cls.is_call;
               state_d  = ST_IF;
            end else begin
               pc_write = 1'b1;
               state_d  = ST_EX;
            end
         end
         ST_EX: begin
            alu_src_imm = cls.is_ialu | cls.is_lw | cls.is_sw;
            if (cls.is_br) begin
               // Branch always reloads PC; pc_control picks target vs PC+1 from flags.
               pc_write = 1'b1;
               state_d  = ST_IF;
            end else if (cls.is_lw || cls.is_sw) begin
               state_d = ST_MEM;
            end else if (is_seq) begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_read  = cls.is_lw;
            dmem_write = cls.is_sw;
            if (cls.is_lw || cls.is_sw) begin
               if (!mem_ready) begin
                  state_d = ST_MEM;
               end else if (cls.is_lw) begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            wb_sel_mem = cls.is_lw;
         end
         default: begin
            state_d = ST_IF;
         end
      endcase

      // A reset abandons the instruction in flight, so no strobe may escape on that cycle.
      if (rst) begin
         state_d     = ST_IF;
         pc_write    = 1'b0;
         ir_write    = 1'b0;
         imem_read   = 1'b0;
         dmem_read   = 1'b0;
         dmem_write  = 1'b0;
         reg_write   = 1'b0;
         alu_src_imm = 1'b0;
         wb_sel_mem  = 1'b0;
         ret_push    = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: directed per-cycle vectors with
// hand-computed state and strobe expectations, checked by a separate monitor.
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'b001100;
   logic       mem_ready = 1'b0;
   logic [2:0] state;
   logic       pc_write, ir_write, imem_read, dmem_read, dmem_write;
   logic       reg_write, alu_src_imm, wb_sel_mem, ret_push;

   // Strobe vector order: pc_write ir_write imem_read dmem_read dmem_write
   //                      reg_write alu_src_imm wb_sel_mem ret_push
   localparam logic [8:0] S_NONE = 9'b000000000;
   localparam logic [8:0] S_IF   = 9'b011000000;
   localparam logic [8:0] S_PCW  = 9'b100000000;
   localparam logic [8:0] S_CALL = 9'b100000001;
   localparam logic [8:0] S_IMM  = 9'b000000100;
   localparam logic [8:0] S_RD   = 9'b000100000;
   localparam logic [8:0] S_WR   = 9'b000010000;
   localparam logic [8:0] S_WB   = 9'b000001000;
   localparam logic [8:0] S_WBM  = 9'b000001010;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [8:0] strb;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   main_control_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .mem_ready   (mem_ready),
      .state       (state),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .imem_read   (imem_read),
      .dmem_read   (dmem_read),
      .dmem_write  (dmem_write),
      .reg_write   (reg_write),
      .alu_src_imm (alu_src_imm),
      .wb_sel_mem  (wb_sel_mem),
      .ret_push    (ret_push)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs just after the edge and queue what that cycle must show.
   task automatic step(input string name, input logic r, input logic [5:0] o,
                       input logic mr, input logic [2:0] st, input logic [8:0] strb);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      op        = o;
      mem_ready = mr;
      e.name = name;
      e.st   = st;
      e.strb = strb;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t       e;
         logic [8:0] got;
         e   = sb.pop_front();
         got = {pc_write, ir_write, imem_read, dmem_read, dmem_write,
                reg_write, alu_src_imm, wb_sel_mem, ret_push};
         n_chk++;
         if (state !== e.st || got !== e.strb) begin
            n_fail++;
            $display("FAIL %s: state=%b strobes=%b, expected state=%b strobes=%b",
                     e.name, state, got, e.st, e.strb);
         end
      end
   end

   initial begin
      // Reset held two cycles with a JMP opcode present
      step("rst_c0",   1'b1, 6'b001100, 1'b0, 3'b000, S_NONE);
      step("rst_c1",   1'b1, 6'b001100, 1'b0, 3'b000, S_NONE);
      step("jmp_if",   1'b0, 6'b001100, 1'b0, 3'b000, S_IF);
      step("jmp_id",   1'b0, 6'b001100, 1'b0, 3'b001, S_PCW);
      // R-type ADD
      step("r_if",     1'b0, 6'b000001, 1'b0, 3'b000, S_IF);
      step("r_id",     1'b0, 6'b000001, 1'b0, 3'b001, S_PCW);
      step("r_ex",     1'b0, 6'b000001, 1'b0, 3'b010, S_NONE);
      step("r_wb",     1'b0, 6'b000001, 1'b0, 3'b100, S_WB);
      // I-ALU
      step("i_if",     1'b0, 6'b000011, 1'b0, 3'b000, S_IF);
      step("i_id",     1'b0, 6'b000011, 1'b0, 3'b001, S_PCW);
      step("i_ex",     1'b0, 6'b000011, 1'b0, 3'b010, S_IMM);
      step("i_wb",     1'b0, 6'b000011, 1'b0, 3'b100, S_WB);
      // LW with three wait cycles
      step("lw_if",    1'b0, 6'b000101, 1'b0, 3'b000, S_IF);
      step("lw_id",    1'b0, 6'b000101, 1'b0, 3'b001, S_PCW);
      step("lw_ex",    1'b0, 6'b000101, 1'b0, 3'b010, S_IMM);
      step("lw_mem0",  1'b0, 6'b000101, 1'b0, 3'b011, S_RD);
      step("lw_mem1",  1'b0, 6'b000101, 1'b0, 3'b011, S_RD);
      step("lw_mem2",  1'b0, 6'b000101, 1'b0, 3'b011, S_RD);
      step("lw_mem3",  1'b0, 6'b000101, 1'b1, 3'b011, S_RD);
      step("lw_wb",    1'b0, 6'b000101, 1'b0, 3'b100, S_WBM);
      // SW, zero wait
      step("sw_if",    1'b0, 6'b000110, 1'b1, 3'b000, S_IF);
      step("sw_id",    1'b0, 6'b000110, 1'b1, 3'b001, S_PCW);
      step("sw_ex",    1'b0, 6'b000110, 1'b1, 3'b010, S_IMM);
      step("sw_mem",   1'b0, 6'b000110, 1'b1, 3'b011, S_WR);
      // Branch resolves in EX
      step("br_if",    1'b0, 6'b001010, 1'b0, 3'b000, S_IF);
      step("br_id",    1'b0, 6'b001010, 1'b0, 3'b001, S_NONE);
      step("br_ex",    1'b0, 6'b001010, 1'b0, 3'b010, S_PCW);
      // CALL and RET
      step("call_if",  1'b0, 6'b001101, 1'b0, 3'b000, S_IF);
      step("call_id",  1'b0, 6'b001101, 1'b0, 3'b001, S_CALL);
      step("ret_if",   1'b0, 6'b001110, 1'b0, 3'b000, S_IF);
      step("ret_id",   1'b0, 6'b001110, 1'b0, 3'b001, S_PCW);
      // SW stalled in MEM, then reset abandons it
      step("swr_if",   1'b0, 6'b000110, 1'b0, 3'b000, S_IF);
      step("swr_id",   1'b0, 6'b000110, 1'b0, 3'b001, S_PCW);
      step("swr_ex",   1'b0, 6'b000110, 1'b0, 3'b010, S_IMM);
      step("swr_mem",  1'b0, 6'b000110, 1'b0, 3'b011, S_WR);
      step("swr_rst",  1'b1, 6'b000110, 1'b0, 3'b011, S_NONE);
      // Unknown opcode follows the NOP path
      step("nop_if",   1'b0, 6'b111111, 1'b0, 3'b000, S_IF);
      step("nop_id",   1'b0, 6'b111111, 1'b0, 3'b001, S_PCW);
      step("end_if",   1'b0, 6'b111111, 1'b0, 3'b000, S_IF);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
